// File: rtl/vga_genlock_timing_gen.sv
// VGA timing generator with camera genlock.
// Measures the incoming HS line period. After LOCK_LINES consecutive matching
// periods, the H/V counters are slaved to the camera HS/VS edges. Otherwise
// they free-run on H_TOTAL / V_TOTAL.
// Optional build macro: VGA_GENLOCK_PATTERN_EN. When it is defined, an 8-bar
// colour test pattern replaces the input pixels while the generator is unlocked.
module vga_genlock_timing_gen #(
    parameter int DW         = 10,
    parameter int CW         = 13,
    parameter int H_TOTAL    = 800,
    parameter int H_SYNC_CYC = 96,
    parameter int X_START    = 144,
    parameter int H_ACT      = 640,
    parameter int V_TOTAL    = 525,
    parameter int V_SYNC_CYC = 2,
    parameter int Y_START    = 35,
    parameter int V_ACT      = 480,
    parameter int REQ_LEAD   = 1,
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_LINES = 4
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iHS,
    input  logic          iVS,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    output logic          oRequest,
    output logic [DW-1:0] oVGA_R,
    output logic [DW-1:0] oVGA_G,
    output logic [DW-1:0] oVGA_B,
    output logic          oVGA_H_SYNC,
    output logic          oVGA_V_SYNC,
    output logic          oVGA_BLANK,
    output logic          oVGA_SYNC,
    output logic          oVGA_CLOCK,
    output logic          oLOCKED,
    output logic [CW-1:0] oH_CNT,
    output logic [CW-1:0] oV_CNT
);

    typedef enum logic [1:0] {FREERUN = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    localparam int MW = $clog2(LOCK_LINES + 1) + 1;

    // All range limits are one bit wider than the counters so that
    // end-of-range values never wrap.
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW:0]   W_ONE   = (CW+1)'(1);
    localparam logic [CW:0]   H_LAST  = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0]   V_LAST  = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0]   HS_END  = (CW+1)'(H_SYNC_CYC);
    localparam logic [CW:0]   VS_END  = (CW+1)'(V_SYNC_CYC);
    localparam logic [CW:0]   X_LO    = (CW+1)'(X_START);
    localparam logic [CW:0]   X_HI    = (CW+1)'(X_START + H_ACT);
    localparam logic [CW:0]   Y_LO    = (CW+1)'(Y_START);
    localparam logic [CW:0]   Y_HI    = (CW+1)'(Y_START + V_ACT);
    localparam logic [CW:0]   REQ_LO  = (CW+1)'(X_START - REQ_LEAD);
    localparam logic [CW:0]   REQ_HI  = (CW+1)'(X_START + H_ACT - REQ_LEAD);
    localparam logic [CW:0]   TOL     = (CW+1)'(LOCK_TOL);
    localparam logic [CW:0]   TMO     = (CW+1)'(2 * H_TOTAL);
    localparam logic [MW-1:0] M_ONE   = MW'(1);
    localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_LINES);

    state_t        state_q;
    logic          locked_q;
    logic [MW-1:0] match_q;
    logic          rhs_q, rvs_q;
    logic [CW-1:0] pcnt_q;
    logic [CW:0]   prev_q;
    logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CW-1:0] hdly_q, vdly_q;
    logic          req_q;

    logic          hs_fall, vs_fall;
    logic [CW:0]   h_x, v_x, hp1, meas, diff;
    logic          period_ok, timeout, h_wrap, h_active, v_active, active;

    assign hs_fall   = rhs_q & ~iHS;
    assign vs_fall   = rvs_q & ~iVS;
    assign h_x       = {1'b0, hcnt_q};
    assign v_x       = {1'b0, vcnt_q};
    assign hp1       = h_x + W_ONE;
    assign meas      = {1'b0, pcnt_q} + W_ONE;
    assign diff      = (meas >= prev_q) ? (meas - prev_q) : (prev_q - meas);
    assign period_ok = (diff <= TOL);
    assign timeout   = ~hs_fall & ({1'b0, pcnt_q} >= TMO);
    assign h_wrap    = (h_x >= H_LAST);
    assign h_active  = (h_x >= X_LO) && (h_x < X_HI);
    assign v_active  = (v_x >= Y_LO) && (v_x < Y_HI);
    assign active    = h_active & v_active;

    assign oVGA_H_SYNC = (h_x >= HS_END);
    assign oVGA_V_SYNC = (v_x >= VS_END);
    assign oVGA_BLANK  = active;
    assign oVGA_SYNC   = 1'b0;
    assign oVGA_CLOCK  = iCLK;
    assign oLOCKED     = locked_q;
    assign oRequest    = req_q;
    assign oH_CNT      = hdly_q;
    assign oV_CNT      = vdly_q;

    // Genlock state machine: acquire after LOCK_LINES matching periods, drop on mismatch or timeout.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= FREERUN;
            match_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                FREERUN: begin
                    if (hs_fall) begin
                        state_q <= ACQUIRE;
                        match_q <= '0;
                    end
                end
                ACQUIRE: begin
                    if (hs_fall) begin
                        if (period_ok) begin
                            if (match_q + M_ONE >= LOCK_N) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                match_q  <= '0;
                            end else begin
                                match_q <= match_q + M_ONE;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end else if (timeout) begin
                        state_q <= FREERUN;
                    end
                end
                LOCKED: begin
                    if ((hs_fall && !period_ok) || timeout) begin
                        state_q  <= FREERUN;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= FREERUN;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Input edge samplers and line-period measurement.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rhs_q  <= 1'b0;
            rvs_q  <= 1'b0;
            pcnt_q <= '0;
            prev_q <= '0;
        end else begin
            rhs_q <= iHS;
            rvs_q <= iVS;
            if (hs_fall) begin
                pcnt_q <= '0;
                prev_q <= meas;
            end else if (pcnt_q != CNT_MAX) begin
                pcnt_q <= pcnt_q + C_ONE;
            end
        end
    end

    // Next counter values: free-run wrap, or slaved to camera edges while locked.
    always_comb begin
        hcnt_d = h_wrap ? '0 : hcnt_q + C_ONE;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = (v_x >= V_LAST) ? '0 : vcnt_q + C_ONE;
        end
        if (state_q == LOCKED) begin
            hcnt_d = hs_fall ? '0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + C_ONE);
            if (vs_fall) begin
                vcnt_d = '0;
            end else if (hs_fall) begin
                vcnt_d = (vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + C_ONE;
            end else begin
                vcnt_d = vcnt_q;
            end
        end
    end

    // Counters, their one-clock-delayed copies and the early pixel request.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            hdly_q <= '0;
            vdly_q <= '0;
            req_q  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hdly_q <= hcnt_q;
            vdly_q <= vcnt_q;
            req_q  <= (hp1 >= REQ_LO) && (hp1 < REQ_HI) && v_active;
        end
    end

`ifdef VGA_GENLOCK_PATTERN_EN
    logic [CW-1:0] bar_off;
    logic [CW+2:0] bar_w;
    logic [2:0]    bar;
    assign bar_off = hcnt_q - X_LO[CW-1:0];
    assign bar_w   = {bar_off, 3'b000} / (CW+3)'(H_ACT);
    assign bar     = 3'(bar_w);
`endif

    // Colour gating: pixels only inside the active window.
    always_comb begin
        oVGA_R = '0;
        oVGA_G = '0;
        oVGA_B = '0;
        if (active) begin
`ifdef VGA_GENLOCK_PATTERN_EN
            if (!locked_q) begin
                oVGA_R = {DW{bar[0]}};
                oVGA_G = {DW{bar[1]}};
                oVGA_B = {DW{bar[2]}};
            end else begin
                oVGA_R = iRed;
                oVGA_G = iGreen;
                oVGA_B = iBlue;
            end
`else
            oVGA_R = iRed;
            oVGA_G = iGreen;
            oVGA_B = iBlue;
`endif
        end
    end

endmodule

// File: tb/tb_vga_genlock_timing_gen.sv
// Scoreboard bench for vga_genlock_timing_gen, using reduced timing so full frames fit in the run.
// The driver pushes expected outputs from a behavioural model each clock.
// The monitor pops and compares them on the falling edge.
module tb_vga_genlock_timing_gen;

    localparam int DW = 10, CW = 8;
    localparam int H_TOTAL = 100, H_SYNC_CYC = 12, X_START = 18, H_ACT = 64;
    localparam int V_TOTAL = 40, V_SYNC_CYC = 2, Y_START = 4, V_ACT = 30;
    localparam int REQ_LEAD = 3, LOCK_TOL = 2, LOCK_LINES = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HS_LOW = 8;
    localparam int M_FREE = 0, M_ACQ = 1, M_LOCK = 2;

    logic          clk = 1'b0;
    logic          iRST_N, iHS, iVS;
    logic [DW-1:0] iRed, iGreen, iBlue;
    logic          oRequest, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC, oVGA_CLOCK, oLOCKED;
    logic [DW-1:0] oVGA_R, oVGA_G, oVGA_B;
    logic [CW-1:0] oH_CNT, oV_CNT;

    vga_genlock_timing_gen #(
        .DW(DW), .CW(CW), .H_TOTAL(H_TOTAL), .H_SYNC_CYC(H_SYNC_CYC), .X_START(X_START),
        .H_ACT(H_ACT), .V_TOTAL(V_TOTAL), .V_SYNC_CYC(V_SYNC_CYC), .Y_START(Y_START),
        .V_ACT(V_ACT), .REQ_LEAD(REQ_LEAD), .LOCK_TOL(LOCK_TOL), .LOCK_LINES(LOCK_LINES)
    ) dut (
        .iCLK(clk), .iRST_N(iRST_N), .iHS(iHS), .iVS(iVS),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oRequest(oRequest), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_H_SYNC(oVGA_H_SYNC), .oVGA_V_SYNC(oVGA_V_SYNC), .oVGA_BLANK(oVGA_BLANK),
        .oVGA_SYNC(oVGA_SYNC), .oVGA_CLOCK(oVGA_CLOCK), .oLOCKED(oLOCKED),
        .oH_CNT(oH_CNT), .oV_CNT(oV_CNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hq, vq, req, lock, hsy, vsy, blank, r, g, b;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mon_cyc = 0;
    int   vs_cnt  = 0;

    // Reference model state: the spec's counters and lock bookkeeping as plain integers.
    int   m_rhs, m_rvs, m_pcnt, m_prev, m_match, m_mode, m_h, m_v, m_hq, m_vq, m_req;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic bit col_active(input int h);
        return (h >= X_START) && (h < X_START + H_ACT);
    endfunction

    function automatic bit row_active(input int v);
        return (v >= Y_START) && (v < Y_START + V_ACT);
    endfunction

    task automatic model_reset();
        m_rhs = 0; m_rvs = 0; m_pcnt = 0; m_prev = 0; m_match = 0;
        m_mode = M_FREE; m_h = 0; m_v = 0; m_hq = 0; m_vq = 0; m_req = 0;
    endtask

    task automatic model_expect(output exp_t e);
        bit act;
        int bar;
        act = col_active(m_h) && row_active(m_v);
        e.hq = m_hq; e.vq = m_vq; e.req = m_req;
        e.lock = (m_mode == M_LOCK) ? 1 : 0;
        e.hsy = (m_h >= H_SYNC_CYC) ? 1 : 0;
        e.vsy = (m_v >= V_SYNC_CYC) ? 1 : 0;
        e.blank = act ? 1 : 0;
        e.r = act ? int'(iRed) : 0;
        e.g = act ? int'(iGreen) : 0;
        e.b = act ? int'(iBlue) : 0;
`ifdef VGA_GENLOCK_PATTERN_EN
        if (act && m_mode != M_LOCK) begin
            bar = (m_h - X_START) * 8 / H_ACT;
            e.r = (bar % 2 == 1) ? (1 << DW) - 1 : 0;
            e.g = ((bar / 2) % 2 == 1) ? (1 << DW) - 1 : 0;
            e.b = ((bar / 4) % 2 == 1) ? (1 << DW) - 1 : 0;
        end
`else
        bar = 0;
        if (bar != 0) e.r = 0;
`endif
    endtask

    task automatic model_step(input bit hs, input bit vs);
        bit hf, vf, ok, tmo, wrap;
        int meas, diff, nh, nv, nmode;
        hf = m_rhs && !hs;
        vf = m_rvs && !vs;
        meas = m_pcnt + 1;
        diff = (meas >= m_prev) ? meas - m_prev : m_prev - meas;
        ok = diff <= LOCK_TOL;
        tmo = !hf && (m_pcnt >= 2 * H_TOTAL);
        if (m_mode == M_LOCK) begin
            nh = hf ? 0 : sat(m_h + 1);
            nv = vf ? 0 : (hf ? sat(m_v + 1) : m_v);
        end else begin
            wrap = m_h >= H_TOTAL - 1;
            nh = wrap ? 0 : m_h + 1;
            nv = !wrap ? m_v : ((m_v >= V_TOTAL - 1) ? 0 : m_v + 1);
        end
        nmode = m_mode;
        if (m_mode == M_FREE) begin
            if (hf) begin nmode = M_ACQ; m_match = 0; end
        end else if (m_mode == M_ACQ) begin
            if (hf) begin
                m_match = ok ? m_match + 1 : 0;
                if (m_match >= LOCK_LINES) begin nmode = M_LOCK; m_match = 0; end
            end else if (tmo) begin
                nmode = M_FREE;
            end
        end else begin
            if ((hf && !ok) || tmo) nmode = M_FREE;
        end
        // Request is due whenever active video starts REQ_LEAD clocks after the next pixel.
        m_req = (col_active(m_h + 1 + REQ_LEAD) && row_active(m_v)) ? 1 : 0;
        m_hq = m_h; m_vq = m_v;
        m_h = nh; m_v = nv; m_mode = nmode;
        m_prev = hf ? meas : m_prev;
        m_pcnt = hf ? 0 : sat(m_pcnt + 1);
        m_rhs = hs; m_rvs = vs;
    endtask

    task automatic drive_cycle(input bit rst_n, input bit hs, input bit vs);
        exp_t e;
        @(posedge clk);
        #1;
        iRST_N = rst_n; iHS = hs; iVS = vs;
        iRed = DW'($urandom); iGreen = DW'($urandom); iBlue = DW'($urandom);
        if (!rst_n) model_reset();
        model_expect(e);
        q.push_back(e);
        if (rst_n) model_step(hs, vs);
    endtask

    task automatic hs_line(input int period, input bit do_vs, input int vs_off);
        for (int i = 0; i < period; i++) begin
            if (do_vs && i == vs_off) vs_cnt = H_TOTAL + 5;
            drive_cycle(1'b1, (i >= HS_LOW), (vs_cnt > 0) ? 1'b0 : 1'b1);
            if (vs_cnt > 0) vs_cnt--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, 1'b1, (vs_cnt > 0) ? 1'b0 : 1'b1);
            if (vs_cnt > 0) vs_cnt--;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, mon_cyc, act, req);
        end
    endtask

    // Monitor: every clock the DUT presents a full output set; compare it against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_cyc++;
            check("h_cnt", 32'(oH_CNT), mon_e.hq);
            check("v_cnt", 32'(oV_CNT), mon_e.vq);
            check("request", 32'(oRequest), mon_e.req);
            check("locked", 32'(oLOCKED), mon_e.lock);
            check("hsync", 32'(oVGA_H_SYNC), mon_e.hsy);
            check("vsync", 32'(oVGA_V_SYNC), mon_e.vsy);
            check("blank", 32'(oVGA_BLANK), mon_e.blank);
            check("red", 32'(oVGA_R), mon_e.r);
            check("green", 32'(oVGA_G), mon_e.g);
            check("blue", 32'(oVGA_B), mon_e.b);
            check("sync_tie", 32'(oVGA_SYNC), 32'd0);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired cycle=%0d actual=running required=finished", mon_cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, per;
        iRST_N = 1'b0; iHS = 1'b1; iVS = 1'b1;
        iRed = '0; iGreen = '0; iBlue = '0;
        model_reset();
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b1);

        $display("[TB] free-run frame with idle camera");
        idle(V_TOTAL * H_TOTAL + 150);

        $display("[TB] acquire lock on nominal lines");
        repeat (8) hs_line(H_TOTAL, 1'b0, 0);

        $display("[TB] locked frames with vsync coincident with hsync");
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < V_TOTAL; l++)
                hs_line(H_TOTAL, (l == 0), 0);

        $display("[TB] long line drops lock, then re-lock");
        hs_line(H_TOTAL + 5, 1'b0, 0);
        repeat (7) hs_line(H_TOTAL, 1'b0, 0);

        $display("[TB] hsync stuck high to force timeout");
        idle(2 * H_TOTAL + 50);

        for (int s = 0; s < 300; s++) begin
            k = $urandom_range(0, 39);
            if (k < 24) begin
                per = H_TOTAL + $urandom_range(0, 4) - 2;
                hs_line(per, 1'b0, 0);
            end else if (k < 30) begin
                per = $urandom_range(20, 180);
                hs_line(per, 1'b0, 0);
            end else if (k < 35) begin
                per = $urandom_range(150, 260);
                idle(per);
            end else if (k < 38) begin
                per = H_TOTAL;
                hs_line(per, 1'b1, $urandom_range(0, H_TOTAL - 1));
            end else if (k < 39) begin
                per = H_TOTAL;
                hs_line(per, 1'b1, 0);
            end else begin
                per = $urandom_range(1, 3);
                repeat (per) drive_cycle(1'b0, 1'b1, 1'b1);
                vs_cnt = 0;
            end
            $display("[TB] seg %0d kind %0d len %0d", s, k, per);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
